// File: rtl/z80_wb_pkg.sv
// Shared constants for the z80 Wishbone I/O peripherals: cycle tags, timer
// register offsets and CTRL bit positions.
package z80_wb_pkg;

  // Wishbone cycle tags driven by the core on wb_tga_i
  localparam logic [1:0] TGA_MEM  = 2'b00;
  localparam logic [1:0] TGA_IO   = 2'b01;
  localparam logic [1:0] TGA_INTA = 2'b10;
  localparam logic [1:0] TGA_RSVD = 2'b11;

  // Timer register offsets within the 8-byte I/O window
  localparam logic [2:0] OFF_CTRL      = 3'd0;
  localparam logic [2:0] OFF_RELOAD_LO = 3'd1;
  localparam logic [2:0] OFF_RELOAD_HI = 3'd2;
  localparam logic [2:0] OFF_COUNT_LO  = 3'd3;
  localparam logic [2:0] OFF_COUNT_HI  = 3'd4;
  localparam logic [2:0] OFF_STATUS    = 3'd5;
  localparam logic [2:0] OFF_VECTOR    = 3'd6;
  localparam logic [2:0] OFF_UNUSED    = 3'd7;

  // CTRL register bit indices
  localparam int unsigned CTRL_EN   = 0;
  localparam int unsigned CTRL_AUTO = 1;
  localparam int unsigned CTRL_IE   = 2;
  localparam int unsigned CTRL_W    = 3;

endpackage

// File: rtl/z80_timer_prescaler.sv
// Clock prescaler for the z80 timer: counts 0..Div-1 while enabled and pulses
// tick_o for one cycle on wrap. Holds at 0 while disabled or cleared.
module z80_timer_prescaler #(
  parameter int unsigned Div = 16
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic en_i,
  input  logic clr_i,
  output logic tick_o
);

  localparam int unsigned CntW = (Div > 1) ? $clog2(Div) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(Div - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  assign tick_o = en_i & (cnt_q == CntMax);

  // Next count: restart on clear, disable or wrap, otherwise advance
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i || !en_i || tick_o) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Prescaler state register with synchronous reset
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/z80_wb_timer_slave.sv
// z80 Wishbone I/O timer: 16-bit down counter with prescaler, reload, expiry
// flag and vectored interrupt. Answers I/O register cycles and int-ack cycles
// with one wait state.
// Optional build macro Z80_WB_TIMER_LATCH_EN: a COUNT_LO read snapshots
// COUNT[15:8] so the following COUNT_HI read is coherent with it.
module z80_wb_timer_slave
  import z80_wb_pkg::*;
#(
  parameter logic [7:0]  IO_BASE      = 8'h40,
  parameter int unsigned PRESCALE_DIV = 16
) (
  input  logic        wb_clk_i,
  input  logic        rst_i,
  input  logic [15:0] wb_adr_i,
  input  logic [7:0]  wb_dat_i,
  input  logic        wb_we_i,
  input  logic        wb_stb_i,
  input  logic        wb_cyc_i,
  input  logic [1:0]  wb_tga_i,
  output logic [7:0]  wb_dat_o,
  output logic        wb_ack_o,
  output logic        int_req_o
);

  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  logic [15:0]       reload_q, reload_d;
  logic [15:0]       count_q, count_d;
  logic              exp_q, exp_d;
  logic [7:0]        vector_q, vector_d;
  logic              pend_q, pend_d;
  logic              ack_q, ack_d;
  logic [7:0]        dat_q, dat_d;
  logic              int_req_q, int_req_d;

  logic       sel_io, sel_inta, sel, acc;
  logic       io_wr, io_rd, inta_acc;
  logic [2:0] offset;
  logic [7:0] rdata, count_hi_rd;
  logic       tick, psc_clr;
  logic       unused_adr;

  assign unused_adr = ^wb_adr_i[15:8];
  assign offset     = wb_adr_i[2:0];

  assign sel_io   = wb_cyc_i & wb_stb_i & (wb_tga_i == TGA_IO) &
                    (wb_adr_i[7:3] == IO_BASE[7:3]);
  assign sel_inta = wb_cyc_i & wb_stb_i & (wb_tga_i == TGA_INTA) & int_req_q;
  assign sel      = sel_io | sel_inta;

  // Selection must still be present on the second edge; that edge is the ack edge
  assign acc      = sel & pend_q;
  assign io_wr    = acc & sel_io & wb_we_i;
  assign io_rd    = acc & sel_io & ~wb_we_i;
  assign inta_acc = acc & sel_inta;

  // EN rising by a CTRL write restarts the prescaler from zero
  assign psc_clr = io_wr & (offset == OFF_CTRL) & ~ctrl_q[CTRL_EN] & wb_dat_i[CTRL_EN];

  z80_timer_prescaler #(
    .Div (PRESCALE_DIV)
  ) u_prescaler (
    .clk_i  (wb_clk_i),
    .rst_i  (rst_i),
    .en_i   (ctrl_q[CTRL_EN]),
    .clr_i  (psc_clr),
    .tick_o (tick)
  );

`ifdef Z80_WB_TIMER_LATCH_EN
  logic [7:0] snap_q, snap_d;

  assign count_hi_rd = snap_q;

  // Capture the high byte whenever the low byte is read
  always_comb begin
    snap_d = snap_q;
    if (io_rd && (offset == OFF_COUNT_LO)) begin
      snap_d = count_q[15:8];
    end
  end

  // Snapshot holding register
  always_ff @(posedge wb_clk_i) begin
    if (rst_i) begin
      snap_q <= '0;
    end else begin
      snap_q <= snap_d;
    end
  end
`else
  assign count_hi_rd = count_q[15:8];
`endif

  // Register read mux
  always_comb begin
    rdata = '0;
    unique case (offset)
      OFF_CTRL:      rdata = {{(8 - CTRL_W){1'b0}}, ctrl_q};
      OFF_RELOAD_LO: rdata = reload_q[7:0];
      OFF_RELOAD_HI: rdata = reload_q[15:8];
      OFF_COUNT_LO:  rdata = count_q[7:0];
      OFF_COUNT_HI:  rdata = count_hi_rd;
      OFF_STATUS:    rdata = {7'b0, exp_q};
      OFF_VECTOR:    rdata = vector_q;
      OFF_UNUSED:    rdata = '0;
    endcase
  end

  // Bus handshake: one wait state, data only during the ack cycle
  always_comb begin
    pend_d = sel & ~pend_q;
    ack_d  = acc;
    dat_d  = '0;
    if (acc) begin
      dat_d = sel_inta ? vector_q : rdata;
    end
  end

  // Register writes, expiry clears, then timer tick (so a tick's set wins)
  always_comb begin
    ctrl_d    = ctrl_q;
    reload_d  = reload_q;
    count_d   = count_q;
    exp_d     = exp_q;
    vector_d  = vector_q;
    int_req_d = exp_q & ctrl_q[CTRL_IE];

    if (io_wr) begin
      case (offset)
        OFF_CTRL: begin
          ctrl_d = wb_dat_i[CTRL_W-1:0];
          if (psc_clr) begin
            count_d = reload_q;
          end
        end
        OFF_RELOAD_LO: reload_d[7:0]  = wb_dat_i;
        OFF_RELOAD_HI: reload_d[15:8] = wb_dat_i;
        OFF_STATUS: begin
          if (wb_dat_i[0]) begin
            exp_d = 1'b0;
          end
        end
        OFF_VECTOR:    vector_d = wb_dat_i;
        default: ;
      endcase
    end

    if (inta_acc) begin
      exp_d = 1'b0;
    end

    if (tick) begin
      if (count_q != 16'h0000) begin
        count_d = count_q - 16'd1;
      end else begin
        exp_d = 1'b1;
        if (ctrl_q[CTRL_AUTO]) begin
          count_d = reload_q;
        end else begin
          ctrl_d[CTRL_EN] = 1'b0;
          count_d         = 16'h0000;
        end
      end
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge wb_clk_i) begin
    if (rst_i) begin
      ctrl_q    <= '0;
      reload_q  <= 16'hFFFF;
      count_q   <= 16'h0000;
      exp_q     <= 1'b0;
      vector_q  <= 8'hFF;
      pend_q    <= 1'b0;
      ack_q     <= 1'b0;
      dat_q     <= '0;
      int_req_q <= 1'b0;
    end else begin
      ctrl_q    <= ctrl_d;
      reload_q  <= reload_d;
      count_q   <= count_d;
      exp_q     <= exp_d;
      vector_q  <= vector_d;
      pend_q    <= pend_d;
      ack_q     <= ack_d;
      dat_q     <= dat_d;
      int_req_q <= int_req_d;
    end
  end

  assign wb_ack_o  = ack_q;
  assign wb_dat_o  = dat_q;
  assign int_req_o = int_req_q;

endmodule

// File: tb/tb_z80_wb_timer_slave.sv
// Self-checking bench for z80_wb_timer_slave: reset-value table, randomized
// register traffic against a register model, timer expiry timing from
// reload/prescale arithmetic, and hand-written corner sequences.
module tb_z80_wb_timer_slave;
  import z80_wb_pkg::*;

  localparam int unsigned DIV  = 16;
  localparam logic [7:0]  BASE = 8'h40;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] adr;
  logic [7:0]  wdat;
  logic        we, stb, cyc;
  logic [1:0]  tga;
  logic [7:0]  rdat;
  logic        ack, irq;

  int checks   = 0;
  int failures = 0;
  int pc       = 0;

  always #5 clk = ~clk;
  always @(posedge clk) pc <= pc + 1;

  z80_wb_timer_slave #(
    .IO_BASE      (BASE),
    .PRESCALE_DIV (DIV)
  ) dut (
    .wb_clk_i  (clk),
    .rst_i     (rst),
    .wb_adr_i  (adr),
    .wb_dat_i  (wdat),
    .wb_we_i   (we),
    .wb_stb_i  (stb),
    .wb_cyc_i  (cyc),
    .wb_tga_i  (tga),
    .wb_dat_o  (rdat),
    .wb_ack_o  (ack),
    .int_req_o (irq)
  );

  // Register model for the randomized phase (timer disabled)
  logic [2:0]  m_ctrl;
  logic [15:0] m_rel;
  logic [7:0]  m_vec;

  function automatic logic [7:0] model_read(input logic [2:0] off);
    case (off)
      3'd0:    return {5'b0, m_ctrl};
      3'd1:    return m_rel[7:0];
      3'd2:    return m_rel[15:8];
      3'd6:    return m_vec;
      default: return 8'h00;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One bus cycle; lat = negedges until ack (0 if none within bound)
  task automatic bus(input logic w, input logic [1:0] t, input logic [15:0] a,
                     input logic [7:0] d, input int bound,
                     output logic [7:0] r, output int lat);
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = w; tga = t; adr = a; wdat = d;
    lat = 0;
    r   = '0;
    for (int i = 1; i <= bound; i++) begin
      @(negedge clk);
      if (ack) begin
        lat = i;
        r   = rdat;
        break;
      end
    end
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
  endtask

  task automatic wr(input logic [2:0] off, input logic [7:0] d);
    logic [7:0] r;
    int lat;
    bus(1'b1, TGA_IO, {8'h00, BASE[7:3], off}, d, 6, r, lat);
    chk("wr_ack_latency", lat, 2);
  endtask

  task automatic rd(input string name, input logic [2:0] off, input logic [7:0] e);
    logic [7:0] r;
    int lat;
    bus(1'b0, TGA_IO, {8'h00, BASE[7:3], off}, 8'h00, 6, r, lat);
    chk({name, "_ack"}, lat, 2);
    chk(name, r, e);
  endtask

  task automatic inta(input logic [7:0] e);
    logic [7:0] r;
    int lat;
    bus(1'b0, TGA_INTA, 16'h0000, 8'h00, 6, r, lat);
    chk("inta_ack", lat, 2);
    chk("inta_vector", r, e);
  endtask

  task automatic wait_irq(input int bound, output int n);
    n = 0;
    for (int i = 1; i <= bound; i++) begin
      @(negedge clk);
      if (irq) begin
        n = i;
        break;
      end
    end
  endtask

  typedef struct packed {
    logic [2:0] off;
    logic [7:0] exp;
  } rd_vec_t;

  rd_vec_t     rst_tab[8];
  logic [7:0]  r, d;
  logic [15:0] a;
  logic [1:0]  t;
  logic [2:0]  off;
  logic        w, hit;
  int          lat, n, r1, e0, rr, ar, acks;

  initial begin
    cyc = 0; stb = 0; we = 0; tga = TGA_MEM; adr = '0; wdat = '0; rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_ack", ack, 0);
    chk("rst_dat", rdat, 0);
    chk("rst_irq", irq, 0);
    rst = 1'b0;

    // Reset values of every offset
    rst_tab[0] = '{3'd0, 8'h00}; rst_tab[1] = '{3'd1, 8'hFF};
    rst_tab[2] = '{3'd2, 8'hFF}; rst_tab[3] = '{3'd3, 8'h00};
    rst_tab[4] = '{3'd4, 8'h00}; rst_tab[5] = '{3'd5, 8'h00};
    rst_tab[6] = '{3'd6, 8'hFF}; rst_tab[7] = '{3'd7, 8'h00};
    for (int i = 0; i < 8; i++) begin
      rd("reset_read", rst_tab[i].off, rst_tab[i].exp);
    end

    // Randomized register traffic with the timer kept disabled
    m_ctrl = 3'h0; m_rel = 16'hFFFF; m_vec = 8'hFF;
    for (int k = 0; k < 60; k++) begin
      t   = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3)) : TGA_IO;
      off = 3'($urandom_range(0, 7));
      a   = {8'($urandom), BASE[7:3], off};
      if ($urandom_range(0, 4) == 0) a[7:3] = BASE[7:3] ^ 5'($urandom_range(1, 31));
      w = 1'($urandom);
      d = 8'($urandom);
      if (off == OFF_CTRL) d[CTRL_EN] = 1'b0;
      hit = (t == TGA_IO) && (a[7:3] == BASE[7:3]);
      bus(w, t, a, d, hit ? 6 : 5, r, lat);
      if (!hit) begin
        chk("rand_ignored", lat, 0);
      end else begin
        chk("rand_ack", lat, 2);
        if (w) begin
          case (off)
            3'd0: m_ctrl = d[2:0];
            3'd1: m_rel[7:0] = d;
            3'd2: m_rel[15:8] = d;
            3'd6: m_vec = d;
            default: ;
          endcase
        end else begin
          chk("rand_read", r, model_read(off));
        end
      end
    end
    wr(OFF_CTRL, 8'h00);

    // Auto-reload expiry and vectored interrupt acknowledge
    wr(OFF_RELOAD_LO, 8'h03);
    wr(OFF_RELOAD_HI, 8'h00);
    wr(OFF_VECTOR, 8'hA5);
    wr(OFF_CTRL, 8'h07);
    wait_irq(200, n);
    chk("irq_rise_cycles", n, DIV * 4 + 1);
    rd("status_exp", OFF_STATUS, 8'h01);
    inta(8'hA5);
    @(negedge clk);
    chk("irq_drop_after_inta", irq, 0);
    wr(OFF_CTRL, 8'h00);
    wr(OFF_STATUS, 8'h01);

    // One-shot expiry clears EN and leaves COUNT at zero
    wr(OFF_RELOAD_LO, 8'h02);
    wr(OFF_CTRL, 8'h05);
    wait_irq(200, n);
    chk("oneshot_rise_cycles", n, DIV * 3 + 1);
    rd("oneshot_ctrl", OFF_CTRL, 8'h04);
    rd("oneshot_cnt_lo", OFF_COUNT_LO, 8'h00);
    rd("oneshot_cnt_hi", OFF_COUNT_HI, 8'h00);
    inta(8'hA5);
    repeat (3 * DIV) @(negedge clk);
    chk("oneshot_no_rearm_irq", irq, 0);
    rd("oneshot_status", OFF_STATUS, 8'h00);

    // Ignored cycles: memory tag, out-of-window I/O, reserved tag
    bus(1'b1, TGA_MEM, {8'h00, BASE}, 8'h11, 10, r, lat);
    chk("mem_no_ack", lat, 0);
    bus(1'b1, TGA_IO, 16'h004E, 8'h22, 10, r, lat);
    chk("io48_no_ack", lat, 0);
    bus(1'b1, TGA_RSVD, {8'h00, BASE[7:3], OFF_VECTOR}, 8'h33, 10, r, lat);
    chk("rsvd_no_ack", lat, 0);
    rd("ignored_vector", OFF_VECTOR, 8'hA5);
    rd("ignored_reload", OFF_RELOAD_LO, 8'h02);
    rd("ignored_ctrl", OFF_CTRL, 8'h04);

    // Held strobe: ack every other cycle
    @(negedge clk);
    cyc = 1; stb = 1; we = 0; tga = TGA_IO; adr = {8'h00, BASE[7:3], OFF_VECTOR};
    acks = 0;
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      chk("held_ack_pattern", ack, (i % 2 == 0) ? 1 : 0);
      if (ack) acks++;
    end
    cyc = 0; stb = 0;
    chk("held_ack_count", acks, 3);

    // Strobe dropped before ack: no ack, no write
    @(negedge clk);
    cyc = 1; stb = 1; we = 1; tga = TGA_IO; adr = {8'h00, BASE[7:3], OFF_VECTOR}; wdat = 8'h3C;
    @(negedge clk);
    cyc = 0; stb = 0; we = 0;
    acks = 0;
    repeat (4) begin
      @(negedge clk);
      if (ack) acks++;
    end
    chk("early_drop_no_ack", acks, 0);
    rd("early_drop_vector", OFF_VECTOR, 8'hA5);

    // STATUS clear on the same edge as an expiry tick: set wins
    wr(OFF_RELOAD_LO, 8'h00);
    wr(OFF_CTRL, 8'h03);
    e0 = pc;
    while (pc < e0 + 2 * DIV - 2) @(negedge clk);
    cyc = 1; stb = 1; we = 1; tga = TGA_IO; adr = {8'h00, BASE[7:3], OFF_STATUS}; wdat = 8'h01;
    @(negedge clk);
    @(negedge clk);
    chk("aligned_clr_ack", ack, 1);
    cyc = 0; stb = 0; we = 0;
    rd("set_wins_status", OFF_STATUS, 8'h01);
    while (pc < e0 + 2 * DIV + 4) @(negedge clk);
    wr(OFF_STATUS, 8'h01);
    rd("plain_clr_status", OFF_STATUS, 8'h00);
    wr(OFF_CTRL, 8'h00);
    wr(OFF_STATUS, 8'h01);

    // COUNT read coherence across a tick
    wr(OFF_RELOAD_HI, 8'h01);
    wr(OFF_CTRL, 8'h01);
    rd("snap_cnt_lo", OFF_COUNT_LO, 8'h00);
    repeat (DIV + 4) @(negedge clk);
`ifdef Z80_WB_TIMER_LATCH_EN
    rd("snap_cnt_hi", OFF_COUNT_HI, 8'h01);
`else
    rd("live_cnt_hi", OFF_COUNT_HI, 8'h00);
`endif
    rd("after_tick_cnt_lo", OFF_COUNT_LO, 8'hFF);
    rd("after_tick_cnt_hi", OFF_COUNT_HI, 8'h00);
    wr(OFF_CTRL, 8'h00);

    // Randomized expiry timing from reload and prescale arithmetic
    for (int k = 0; k < 6; k++) begin
      rr = $urandom_range(0, 4);
      ar = $urandom_range(0, 1);
      wr(OFF_STATUS, 8'h01);
      wr(OFF_RELOAD_LO, 8'(rr));
      wr(OFF_RELOAD_HI, 8'h00);
      wr(OFF_CTRL, 8'(5 + 2 * ar));
      wait_irq(DIV * 6 + 4, n);
      chk("rand_expiry_cycles", n, DIV * (rr + 1) + 1);
      r1 = pc;
      inta(8'hA5);
      @(negedge clk);
      chk("rand_irq_cleared", irq, 0);
      if (ar == 1) begin
        wait_irq(DIV * 6 + 4, n);
        chk("rand_reload_period", pc - r1, DIV * (rr + 1));
      end else begin
        rd("rand_oneshot_ctrl", OFF_CTRL, 8'h04);
        rd("rand_oneshot_cnt", OFF_COUNT_LO, 8'h00);
      end
      wr(OFF_CTRL, 8'h00);
      wr(OFF_STATUS, 8'h01);
    end

    // Reset during a pending ack with EXP set
    wr(OFF_RELOAD_LO, 8'h00);
    wr(OFF_RELOAD_HI, 8'h00);
    wr(OFF_CTRL, 8'h07);
    wait_irq(DIV * 2 + 4, n);
    chk("pre_reset_irq_cycles", n, DIV + 1);
    @(negedge clk);
    cyc = 1; stb = 1; we = 0; tga = TGA_IO; adr = {8'h00, BASE[7:3], OFF_VECTOR};
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_ack", ack, 0);
    chk("midrst_dat", rdat, 0);
    chk("midrst_irq", irq, 0);
    rst = 1'b0; cyc = 0; stb = 0;
    rd("post_rst_ctrl", OFF_CTRL, 8'h00);
    rd("post_rst_reload_lo", OFF_RELOAD_LO, 8'hFF);
    rd("post_rst_reload_hi", OFF_RELOAD_HI, 8'hFF);
    rd("post_rst_status", OFF_STATUS, 8'h00);
    rd("post_rst_vector", OFF_VECTOR, 8'hFF);
    rd("post_rst_cnt_lo", OFF_COUNT_LO, 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
